// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the float <-> int conversion paths.
package fpu_pkg;

  // RISC-V rounding-mode encoding; values 5-7 fall through to truncation.
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Float -> int converter sequencing.
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ROUND  = 3'd3,
    PACK   = 3'd4,
    PUT_Z  = 3'd5
  } f2i_state_e;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam int          F32_BIAS  = 127;

  // A magnitude no int32 can hold; loading it makes the final range check saturate.
  localparam logic [32:0] M_SATURATE = 33'h1_0000_0000;

  // The only binary32 value with exponent 31 that still fits in int32: -2^31.
  localparam logic [31:0] F32_NEG_2P31 = 32'hCF00_0000;

  // Exponent field all ones: infinity or NaN.
  function automatic logic f32_exp_max(input logic [31:0] f);
    return (f[30:23] == 8'hFF);
  endfunction

  // Exponent all ones with a non-zero fraction.
  function automatic logic f32_is_nan(input logic [31:0] f);
    return f32_exp_max(f) && (f[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/f2i_round_dec.sv
// Rounding-increment decision from sign, guard, sticky and result LSB.
// Shared by the float->int and int->float rounding steps.
module f2i_round_dec
  import fpu_pkg::*;
(
  input  logic       s,
  input  logic       g,
  input  logic       st,
  input  logic       lsb,
  input  logic [2:0] rm,
  output logic       inc
);

  // Pick the increment for the active rounding mode; unknown modes truncate.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (st | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s & (g | st);
      RM_RUP:  inc = ~s & (g | st);
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/float_to_int.sv
// Multi-cycle binary32 -> int32 converter (FCVT.W.S) with stb/ack handshakes.
// The significand is shifted right one bit per cycle until its binary point
// sits below bit 0, then rounded, range-checked and negated if needed.
module float_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [2:0]  rm,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_nv,
  output logic        output_z_nx,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  f2i_state_e         state_reg;
  logic [31:0]        a_reg;
  logic [2:0]         rm_reg;
  logic               s_reg;
  logic signed [9:0]  e_reg;
  logic [32:0]        m_reg;
  logic               g_reg;
  logic               st_reg;

  logic signed [9:0]  exp_unb;
  logic               a_nan;
  logic               a_inf;
  logic               a_big;
  logic               a_tiny;
  logic               round_inc;

  // Decode the captured operand for the UNPACK step.
  always_comb begin
    exp_unb = $signed({2'b00, a_reg[30:23]}) - $signed(10'(F32_BIAS));
    a_nan   = f32_is_nan(a_reg);
    a_inf   = f32_exp_max(a_reg) && !a_nan;
    a_big   = (exp_unb >= 10'sd31);
    a_tiny  = (exp_unb < -10'sd1);
  end

  f2i_round_dec u_round_dec (
    .s   (s_reg),
    .g   (g_reg),
    .st  (st_reg),
    .lsb (m_reg[0]),
    .rm  (rm_reg),
    .inc (round_inc)
  );

  // Conversion sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= GET_A;
      a_reg        <= '0;
      rm_reg       <= '0;
      s_reg        <= 1'b0;
      e_reg        <= '0;
      m_reg        <= '0;
      g_reg        <= 1'b0;
      st_reg       <= 1'b0;
      input_a_ack  <= 1'b0;
      output_z     <= '0;
      output_z_nv  <= 1'b0;
      output_z_nx  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      case (state_reg)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_stb && input_a_ack) begin
            a_reg       <= input_a;
            rm_reg      <= rm;
            input_a_ack <= 1'b0;
            state_reg   <= UNPACK;
          end
        end

        UNPACK: begin
          s_reg  <= a_reg[31];
          g_reg  <= 1'b0;
          st_reg <= 1'b0;
          if (a_nan) begin
            // NaN always saturates positive regardless of its sign bit.
            s_reg     <= 1'b0;
            m_reg     <= M_SATURATE;
            state_reg <= PACK;
          end else if (a_inf) begin
            m_reg     <= M_SATURATE;
            state_reg <= PACK;
          end else if (a_big) begin
            // -2^31 is representable; every other |x| >= 2^31 overflows.
            m_reg     <= (a_reg == F32_NEG_2P31) ? {1'b0, INT32_MIN} : M_SATURATE;
            state_reg <= PACK;
          end else if (a_tiny) begin
            // |x| < 0.5: only the sticky bit survives (zero stays exact).
            m_reg     <= '0;
            st_reg    <= (a_reg[30:0] != 31'd0);
            state_reg <= ROUND;
          end else begin
            // Hidden one at bit 31: value = m * 2^(e-31).
            m_reg     <= {1'b0, 1'b1, a_reg[22:0], 8'b0};
            e_reg     <= exp_unb;
            state_reg <= ALIGN;
          end
        end

        ALIGN: begin
          m_reg  <= {2'b00, m_reg[31:1]};
          g_reg  <= m_reg[0];
          st_reg <= st_reg | g_reg;
          e_reg  <= e_reg + 10'sd1;
          // This shift brings e to 31, so the integer part is fully aligned.
          if (e_reg == 10'sd30) begin
            state_reg <= ROUND;
          end
        end

        ROUND: begin
          m_reg     <= m_reg + {32'd0, round_inc};
          state_reg <= PACK;
        end

        PACK: begin
          if (!s_reg && (m_reg > {1'b0, INT32_MAX})) begin
            output_z    <= INT32_MAX;
            output_z_nv <= 1'b1;
            output_z_nx <= 1'b0;
          end else if (s_reg && (m_reg > {1'b0, INT32_MIN})) begin
            output_z    <= INT32_MIN;
            output_z_nv <= 1'b1;
            output_z_nx <= 1'b0;
          end else begin
            output_z    <= s_reg ? (32'd0 - m_reg[31:0]) : m_reg[31:0];
            output_z_nv <= 1'b0;
            output_z_nx <= g_reg | st_reg;
          end
          output_z_stb <= 1'b1;
          state_reg    <= PUT_Z;
        end

        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state_reg    <= GET_A;
          end
        end

        default: begin
          input_a_ack  <= 1'b0;
          output_z_stb <= 1'b0;
          state_reg    <= GET_A;
        end
      endcase
    end
  end

endmodule
